// File: rtl/cc_collision_scan_ctrl_if.sv
// ============================================================================
// Module      : cc_collision_scan_ctrl_if
// Description : Handshake and row-bus bundle between the collision scan
//               controller, the frame tick, the row multiplexers and the
//               game FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cc_collision_scan_ctrl_if #(
    parameter int MATRIX_DATAWIDTH     = 8,
    parameter int MATRIX_ROWADDR_WIDTH = 3
);
    logic                              CC_COLLISIONSCAN_start_InHigh;
    logic                              CC_COLLISIONSCAN_enable_InHigh;
    logic [MATRIX_DATAWIDTH-1:0]       CC_COLLISIONSCAN_frogRow_InBUS;
    logic [MATRIX_DATAWIDTH-1:0]       CC_COLLISIONSCAN_obstacleRow_InBUS;
    logic [MATRIX_ROWADDR_WIDTH-1:0]   CC_COLLISIONSCAN_rowAddr_OutBUS;
    logic                              CC_COLLISIONSCAN_busy_OutHigh;
    logic                              CC_COLLISIONSCAN_done_OutHigh;
    logic                              CC_COLLISIONSCAN_crash_OutLow;
    logic [MATRIX_ROWADDR_WIDTH-1:0]   CC_COLLISIONSCAN_hitRow_OutBUS;
    logic [MATRIX_ROWADDR_WIDTH:0]     CC_COLLISIONSCAN_hitCount_OutBUS;

    // Environment side: frame tick, row muxes and game FSM.
    modport master (
        output CC_COLLISIONSCAN_start_InHigh,
        output CC_COLLISIONSCAN_enable_InHigh,
        output CC_COLLISIONSCAN_frogRow_InBUS,
        output CC_COLLISIONSCAN_obstacleRow_InBUS,
        input  CC_COLLISIONSCAN_rowAddr_OutBUS,
        input  CC_COLLISIONSCAN_busy_OutHigh,
        input  CC_COLLISIONSCAN_done_OutHigh,
        input  CC_COLLISIONSCAN_crash_OutLow,
        input  CC_COLLISIONSCAN_hitRow_OutBUS,
        input  CC_COLLISIONSCAN_hitCount_OutBUS
    );

    // Controller side.
    modport slave (
        input  CC_COLLISIONSCAN_start_InHigh,
        input  CC_COLLISIONSCAN_enable_InHigh,
        input  CC_COLLISIONSCAN_frogRow_InBUS,
        input  CC_COLLISIONSCAN_obstacleRow_InBUS,
        output CC_COLLISIONSCAN_rowAddr_OutBUS,
        output CC_COLLISIONSCAN_busy_OutHigh,
        output CC_COLLISIONSCAN_done_OutHigh,
        output CC_COLLISIONSCAN_crash_OutLow,
        output CC_COLLISIONSCAN_hitRow_OutBUS,
        output CC_COLLISIONSCAN_hitCount_OutBUS
    );
endinterface

`default_nettype wire

// File: rtl/cc_collision_scan_ctrl.sv
// ============================================================================
// Module      : cc_collision_scan_ctrl
// Description : Scans the 8x8 LED matrix one row per clock, ANDs the frog and
//               obstacle rows and publishes crash flag, first hit row and hit
//               count at the end of each scan.
//               Optional macro CC_COLLISIONSCAN_EARLYEXIT_EN: finish the scan
//               on the first overlapping row.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_collision_scan_ctrl #(
    parameter int MATRIX_DATAWIDTH     = 8,
    parameter int MATRIX_ROWS          = 8,
    parameter int MATRIX_ROWADDR_WIDTH = 3
) (
    input  wire logic               CC_COLLISIONSCAN_CLOCK_50,
    input  wire logic               CC_COLLISIONSCAN_RESET_InLow,
    cc_collision_scan_ctrl_if.slave scanIf
);

    localparam int AW = MATRIX_ROWADDR_WIDTH;
    localparam logic [AW-1:0] c_lastRow  = AW'(MATRIX_ROWS - 1);
    localparam logic [AW:0]   c_countOne = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state,    w_state;
    logic [AW-1:0] r_rowAddr,  w_rowAddr;
    logic          r_busy,     w_busy;
    logic          r_done,     w_done;
    logic          r_crashN,   w_crashN;
    logic [AW-1:0] r_hitRow,   w_hitRow;
    logic [AW:0]   r_hitCount, w_hitCount;
    logic          r_hitFlag,  w_hitFlag;
    logic [AW-1:0] r_firstRow, w_firstRow;
    logic [AW:0]   r_count,    w_count;
    logic          w_rowHit;

    assign w_rowHit = |(scanIf.CC_COLLISIONSCAN_frogRow_InBUS &
                        scanIf.CC_COLLISIONSCAN_obstacleRow_InBUS);

    // Register state, scratch accumulators and all published outputs.
    always_ff @(posedge CC_COLLISIONSCAN_CLOCK_50 or negedge CC_COLLISIONSCAN_RESET_InLow) begin
        if (!CC_COLLISIONSCAN_RESET_InLow) begin
            r_state    <= IDLE;
            r_rowAddr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_crashN   <= 1'b1;
            r_hitRow   <= '0;
            r_hitCount <= '0;
            r_hitFlag  <= 1'b0;
            r_firstRow <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state;
            r_rowAddr  <= w_rowAddr;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_crashN   <= w_crashN;
            r_hitRow   <= w_hitRow;
            r_hitCount <= w_hitCount;
            r_hitFlag  <= w_hitFlag;
            r_firstRow <= w_firstRow;
            r_count    <= w_count;
        end
    end

    // Next-state and next-output decode; a low enable freezes everything
    // except done, which is a pulse and drops on any edge after it fires.
    always_comb begin
        w_state    = r_state;
        w_rowAddr  = r_rowAddr;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_crashN   = r_crashN;
        w_hitRow   = r_hitRow;
        w_hitCount = r_hitCount;
        w_hitFlag  = r_hitFlag;
        w_firstRow = r_firstRow;
        w_count    = r_count;
        if (scanIf.CC_COLLISIONSCAN_enable_InHigh) begin
            case (r_state)
                IDLE: begin
                    w_rowAddr = '0;
                    if (scanIf.CC_COLLISIONSCAN_start_InHigh) begin
                        w_state    = SCAN;
                        w_busy     = 1'b1;
                        w_hitFlag  = 1'b0;
                        w_firstRow = '0;
                        w_count    = '0;
                    end
                end
                SCAN: begin
                    if (w_rowHit) begin
                        w_count = r_count + c_countOne;
                        if (!r_hitFlag) begin
                            w_hitFlag  = 1'b1;
                            w_firstRow = r_rowAddr;
                        end
                    end
                    if (r_rowAddr == c_lastRow) begin
                        w_state = DONE;
                    end else begin
                        w_rowAddr = r_rowAddr + 1'b1;
                    end
`ifdef CC_COLLISIONSCAN_EARLYEXIT_EN
                    // The first overlap is all the game needs: stop here.
                    if (w_rowHit) begin
                        w_state   = DONE;
                        w_rowAddr = r_rowAddr;
                    end
`else
`endif
                end
                DONE: begin
                    w_done     = 1'b1;
                    w_crashN   = ~r_hitFlag;
                    w_hitRow   = r_hitFlag ? r_firstRow : '0;
                    w_hitCount = r_count;
                    w_busy     = 1'b0;
                    w_rowAddr  = '0;
                    w_state    = IDLE;
                end
                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

    assign scanIf.CC_COLLISIONSCAN_rowAddr_OutBUS  = r_rowAddr;
    assign scanIf.CC_COLLISIONSCAN_busy_OutHigh    = r_busy;
    assign scanIf.CC_COLLISIONSCAN_done_OutHigh    = r_done;
    assign scanIf.CC_COLLISIONSCAN_crash_OutLow    = r_crashN;
    assign scanIf.CC_COLLISIONSCAN_hitRow_OutBUS   = r_hitRow;
    assign scanIf.CC_COLLISIONSCAN_hitCount_OutBUS = r_hitCount;

endmodule

`default_nettype wire

// File: tb/tb_cc_collision_scan_ctrl.sv
// ============================================================================
// Module      : tb_cc_collision_scan_ctrl
// Description : Self-checking bench for cc_collision_scan_ctrl. Expected scan
//               results are queued at start and checked when done fires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cc_collision_scan_ctrl;

    localparam int ROWS = 8;

    typedef struct {
        logic       crashN;
        logic [2:0] hitRow;
        logic [3:0] hitCount;
        int         doneCyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   lastStart = 0;
    int   nTests = 0;
    int   nFails = 0;
    exp_t sb[$];

    logic [7:0] frogMem [ROWS];
    logic [7:0] obsMem  [ROWS];

    cc_collision_scan_ctrl_if #(.MATRIX_DATAWIDTH(8), .MATRIX_ROWADDR_WIDTH(3)) ifc ();

    cc_collision_scan_ctrl #(
        .MATRIX_DATAWIDTH(8),
        .MATRIX_ROWS(ROWS),
        .MATRIX_ROWADDR_WIDTH(3)
    ) dut (
        .CC_COLLISIONSCAN_CLOCK_50   (clk),
        .CC_COLLISIONSCAN_RESET_InLow(rst_n),
        .scanIf                      (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External row multiplexers: combinational on the DUT row address.
    assign ifc.CC_COLLISIONSCAN_frogRow_InBUS     = frogMem[ifc.CC_COLLISIONSCAN_rowAddr_OutBUS];
    assign ifc.CC_COLLISIONSCAN_obstacleRow_InBUS = obsMem[ifc.CC_COLLISIONSCAN_rowAddr_OutBUS];

    logic       done, busy, crashN;
    logic [2:0] rowAddr, hitRow;
    logic [3:0] hitCount;
    assign done     = ifc.CC_COLLISIONSCAN_done_OutHigh;
    assign busy     = ifc.CC_COLLISIONSCAN_busy_OutHigh;
    assign crashN   = ifc.CC_COLLISIONSCAN_crash_OutLow;
    assign rowAddr  = ifc.CC_COLLISIONSCAN_rowAddr_OutBUS;
    assign hitRow   = ifc.CC_COLLISIONSCAN_hitRow_OutBUS;
    assign hitCount = ifc.CC_COLLISIONSCAN_hitCount_OutBUS;

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            nTests++;
            if (sb.size() == 0) begin
                nFails++;
                $display("FAIL sb_unexpected_done: done=1 at cycle %0d, required no pending scan", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({crashN, hitRow, hitCount} !== {e.crashN, e.hitRow, e.hitCount} || cyc != e.doneCyc) begin
                    nFails++;
                    $display("FAIL sb_result: got crashN=%b hitRow=%0d hitCount=%0d cyc=%0d, required crashN=%b hitRow=%0d hitCount=%0d cyc=%0d",
                             crashN, hitRow, hitCount, cyc, e.crashN, e.hitRow, e.hitCount, e.doneCyc);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearRows;
        for (int r = 0; r < ROWS; r++) begin
            frogMem[r] = 8'h00;
            obsMem[r]  = 8'h00;
        end
    endtask

    // Reference result of a scan over the current row tables; doneCyc holds
    // the latency from the start edge, extended by any paused edges.
    function automatic exp_t model(input int extra);
        exp_t e;
        int   n;
        int   first;
        n = 0;
        first = -1;
        for (int r = 0; r < ROWS; r++) begin
            if ((frogMem[r] & obsMem[r]) != 8'h00) begin
                if (first < 0) first = r;
                n++;
            end
        end
        e.doneCyc = ROWS + 1 + extra;
`ifdef CC_COLLISIONSCAN_EARLYEXIT_EN
        if (first >= 0) begin
            n = 1;
            e.doneCyc = first + 2 + extra;
        end
`else
`endif
        e.crashN   = (n == 0);
        e.hitRow   = (first < 0) ? 3'd0 : 3'(first);
        e.hitCount = 4'(n);
        return e;
    endfunction

    // Pulse start for one edge and queue the expected outcome.
    task automatic startScan(input int extra);
        exp_t e;
        e = model(extra);
        ifc.CC_COLLISIONSCAN_start_InHigh = 1'b1;
        tick();
        ifc.CC_COLLISIONSCAN_start_InHigh = 1'b0;
        lastStart = cyc;
        e.doneCyc = e.doneCyc + cyc;
        sb.push_back(e);
    endtask

    // Bounded wait for done; returns cycles since the last start edge or -1.
    task automatic waitDone(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) begin
                at = cyc - lastStart;
                break;
            end
        end
    endtask

    task automatic test_reset;
        ifc.CC_COLLISIONSCAN_start_InHigh  = 1'b0;
        ifc.CC_COLLISIONSCAN_enable_InHigh = 1'b1;
        clearRows();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            nTests++;
            if ({crashN, busy, done, hitRow, hitCount, rowAddr} !== {1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 3'd0}) begin
                nFails++;
                $display("FAIL reset_idle: cycle %0d crashN=%b busy=%b done=%b hitRow=%0d hitCount=%0d rowAddr=%0d, required 1/0/0/0/0/0",
                         i, crashN, busy, done, hitRow, hitCount, rowAddr);
            end
        end
    endtask

    task automatic test_no_hit;
        logic [2:0] expRow;
        clearRows();
        frogMem[2] = 8'h10;
        for (int r = 0; r < ROWS; r++) obsMem[r] = 8'h0F;
        startScan(0);
        nTests++;
        if (busy !== 1'b1 || rowAddr !== 3'd0) begin
            nFails++;
            $display("FAIL nohit_start: busy=%b rowAddr=%0d, required 1/0", busy, rowAddr);
        end
        for (int n = 1; n <= ROWS; n++) begin
            tick();
            expRow = (n < ROWS) ? 3'(n) : 3'(ROWS - 1);
            nTests++;
            if (rowAddr !== expRow || busy !== 1'b1 || done !== 1'b0) begin
                nFails++;
                $display("FAIL nohit_step: edge %0d rowAddr=%0d busy=%b done=%b, required %0d/1/0", n, rowAddr, busy, done, expRow);
            end
        end
        tick();
        nTests++;
        if (done !== 1'b1 || busy !== 1'b0 || rowAddr !== 3'd0 || crashN !== 1'b1 || hitCount !== 4'd0) begin
            nFails++;
            $display("FAIL nohit_done: done=%b busy=%b rowAddr=%0d crashN=%b hitCount=%0d, required 1/0/0/1/0",
                     done, busy, rowAddr, crashN, hitCount);
        end
        tick();
        nTests++;
        if (done !== 1'b0) begin
            nFails++;
            $display("FAIL nohit_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_two_hits;
        int at;
        int expAt;
        clearRows();
        frogMem[3] = 8'h18;
        obsMem[3]  = 8'h08;
        frogMem[5] = 8'h20;
        obsMem[5]  = 8'h28;
        startScan(0);
        waitDone(at);
`ifdef CC_COLLISIONSCAN_EARLYEXIT_EN
        expAt = 5;
`else
        expAt = 9;
`endif
        nTests++;
        if (at != expAt) begin
            nFails++;
            $display("FAIL twohit_latency: done at %0d, required %0d", at, expAt);
        end
        nTests++;
        if (crashN !== 1'b0 || hitRow !== 3'd3) begin
            nFails++;
            $display("FAIL twohit_result: crashN=%b hitRow=%0d, required 0/3", crashN, hitRow);
        end
        tick();
    endtask

    task automatic test_pause;
        int at;
        int expAt;
        // Part 1: pause in the middle of a scan.
        clearRows();
        frogMem[6] = 8'h01;
        obsMem[6]  = 8'h01;
        frogMem[7] = 8'h02;
        obsMem[7]  = 8'h02;
        startScan(4);
        repeat (4) tick();
        nTests++;
        if (rowAddr !== 3'd4) begin
            nFails++;
            $display("FAIL pause_pre: rowAddr=%0d, required 4", rowAddr);
        end
        ifc.CC_COLLISIONSCAN_enable_InHigh = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            nTests++;
            if (rowAddr !== 3'd4 || busy !== 1'b1 || done !== 1'b0) begin
                nFails++;
                $display("FAIL pause_hold: paused edge %0d rowAddr=%0d busy=%b done=%b, required 4/1/0", i, rowAddr, busy, done);
            end
        end
        ifc.CC_COLLISIONSCAN_enable_InHigh = 1'b1;
        waitDone(at);
`ifdef CC_COLLISIONSCAN_EARLYEXIT_EN
        expAt = 12;
`else
        expAt = 13;
`endif
        nTests++;
        if (at != expAt) begin
            nFails++;
            $display("FAIL pause_latency: done at %0d, required %0d", at, expAt);
        end
        tick();
        // Part 2: pause while DONE is pending.
        clearRows();
        startScan(2);
        repeat (ROWS) tick();
        ifc.CC_COLLISIONSCAN_enable_InHigh = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            nTests++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                nFails++;
                $display("FAIL pause_done_hold: done=%b busy=%b, required 0/1", done, busy);
            end
        end
        ifc.CC_COLLISIONSCAN_enable_InHigh = 1'b1;
        tick();
        nTests++;
        if (done !== 1'b1 || cyc - lastStart != ROWS + 3) begin
            nFails++;
            $display("FAIL pause_done_release: done=%b at %0d, required 1 at %0d", done, cyc - lastStart, ROWS + 3);
        end
        tick();
    endtask

    task automatic test_restart_ignored;
        int pulses;
        clearRows();
        frogMem[2] = 8'h10;
        for (int r = 0; r < ROWS; r++) obsMem[r] = 8'h0F;
        startScan(0);
        repeat (6) tick();
        ifc.CC_COLLISIONSCAN_start_InHigh = 1'b1;
        tick();
        ifc.CC_COLLISIONSCAN_start_InHigh = 1'b0;
        tick();
        ifc.CC_COLLISIONSCAN_start_InHigh = 1'b1;
        pulses = 0;
        tick();
        if (done === 1'b1) pulses++;
        ifc.CC_COLLISIONSCAN_start_InHigh = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        nTests++;
        if (pulses != 1 || busy !== 1'b0) begin
            nFails++;
            $display("FAIL restart_ignored: done pulses=%0d busy=%b, required 1/0", pulses, busy);
        end
    endtask

    task automatic test_reset_midscan;
        int at;
        clearRows();
        frogMem[3] = 8'h18;
        obsMem[3]  = 8'h08;
        startScan(0);
        waitDone(at);
        tick();
        nTests++;
        if (crashN !== 1'b0) begin
            nFails++;
            $display("FAIL rstmid_precrash: crashN=%b, required 0", crashN);
        end
        clearRows();
        frogMem[7] = 8'h80;
        obsMem[7]  = 8'h80;
        startScan(0);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        nTests++;
        if ({crashN, busy, done, rowAddr, hitRow, hitCount} !== {1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0}) begin
            nFails++;
            $display("FAIL rstmid_async: crashN=%b busy=%b done=%b rowAddr=%0d hitRow=%0d hitCount=%0d, required 1/0/0/0/0/0",
                     crashN, busy, done, rowAddr, hitRow, hitCount);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            nTests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                nFails++;
                $display("FAIL rstmid_nodone: done=%b busy=%b, required 0/0", done, busy);
            end
        end
        startScan(0);
        waitDone(at);
        nTests++;
        if (at != 9 || crashN !== 1'b0 || hitRow !== 3'd7 || hitCount !== 4'd1) begin
            nFails++;
            $display("FAIL rstmid_rescan: at=%0d crashN=%b hitRow=%0d hitCount=%0d, required 9/0/7/1", at, crashN, hitRow, hitCount);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int   firstDone;
        int   at;
        exp_t e;
        clearRows();
        frogMem[6] = 8'h01;
        obsMem[6]  = 8'h01;
        frogMem[7] = 8'h02;
        obsMem[7]  = 8'h02;
        e = model(0);
        ifc.CC_COLLISIONSCAN_start_InHigh = 1'b1;
        tick();
        lastStart = cyc;
        e.doneCyc = e.doneCyc + cyc;
        sb.push_back(e);
        waitDone(at);
        firstDone = cyc;
        e = model(0);
        tick();
        lastStart = cyc;
        e.doneCyc = e.doneCyc + cyc;
        sb.push_back(e);
        ifc.CC_COLLISIONSCAN_start_InHigh = 1'b0;
        nTests++;
        if (busy !== 1'b1 || at < 0) begin
            nFails++;
            $display("FAIL b2b_restart: busy=%b first done at %0d, required busy 1", busy, at);
        end
        waitDone(at);
        nTests++;
        if (cyc - firstDone != at + 1) begin
            nFails++;
            $display("FAIL b2b_period: period=%0d, required %0d", cyc - firstDone, at + 1);
        end
        tick();
    endtask

    initial begin
        ifc.CC_COLLISIONSCAN_start_InHigh  = 1'b0;
        ifc.CC_COLLISIONSCAN_enable_InHigh = 1'b1;
        test_reset();
        test_no_hit();
        test_two_hits();
        test_pause();
        test_restart_ignored();
        test_reset_midscan();
        test_back_to_back();
        repeat (3) tick();
        nTests++;
        if (sb.size() != 0) begin
            nFails++;
            $display("FAIL sb_drain: %0d scans never completed, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule

`default_nettype wire
